pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 Parameter: ADDR_BITS, default 13, width of the pixel RAM address.
REQ-002 Parameter: NUM_PIXELS, default 2**ADDR_BITS, pixels sent per frame; legal range 1..2**ADDR_BITS.
REQ-003 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin sending a frame.
REQ-006 mode  input  2  output format, sampled only on an accepted start: 0 = gray (1 byte/pixel), 1 = gray x3 (3 bytes/pixel), 2 = raw RGB (3 bytes/pixel), 3 = reserved, treated as 0.
REQ-007 ram_addr  output  ADDR_BITS  registered pixel RAM read address.
REQ-008 ram_rd_data  input  24  pixel from synchronous RAM; R=[23:16], G=[15:8], B=[7:0]; valid one cycle after ram_addr.
REQ-009 tx_full  input  1  UART transmit FIFO full.
REQ-010 wr_uart  output  1  one-cycle write strobe to the UART.
REQ-011 w_data  output  8  byte to the UART, valid while wr_uart=1.
REQ-012 busy  output  1  high from an accepted start until the cycle in which done pulses.
REQ-013 done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, FETCH, LATCH, SEND and DONE.
REQ-015 In IDLE, start=1 SHALL be accepted: latch mode, set pixel index to 0, drive ram_addr=0, and go to FETCH.
REQ-016 start SHALL be ignored in every state other than IDLE; a change on mode SHALL NOT affect a frame in progress.
REQ-017 FETCH SHALL hold ram_addr = index for one cycle, then go to LATCH.
REQ-018 LATCH SHALL capture ram_rd_data into an internal pixel register, set the byte counter to 0, and go to SEND.
REQ-019 In SEND, wr_uart SHALL be 1 in a cycle only when tx_full=0; each such cycle transmits one byte and increments the byte counter.
REQ-020 In SEND with tx_full=1, wr_uart SHALL be 0 and the byte counter and pixel register SHALL hold; no byte is lost or duplicated.
REQ-021 Byte order per mode:
  - mode 0/3: gray.
  - mode 1: gray, gray, gray.
  - mode 2: R, G, B.
REQ-022 Gray SHALL be (R + 2*G + B) >> 2, computed at 10 bits, truncated with no rounding, and SHALL always fit in 8 bits.
REQ-023 After the last byte of a pixel:
  - if index = NUM_PIXELS-1: go to DONE.
  - otherwise: index increments, ram_addr = index+1, go to FETCH.
REQ-024 The index SHALL NOT wrap inside a frame; each address 0..NUM_PIXELS-1 SHALL be read exactly once, in ascending order.
REQ-025 DONE SHALL assert done=1 and busy=0 for one cycle, then return to IDLE; a start in the following cycle SHALL begin a new frame.
REQ-026 With tx_full held 0, each pixel SHALL take 2 + (bytes per pixel) cycles (FETCH, LATCH, then the SEND cycles).
REQ-027 wr_uart SHALL never be 1 outside SEND; w_data SHALL be 0 whenever wr_uart=0.

Reset
REQ-028 On reset, regardless of state: FSM=IDLE; ram_addr=0, index=0, byte counter=0, pixel register=0, latched mode=0; wr_uart=0, w_data=0, busy=0, done=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no further UART writes, and SHALL NOT produce a done pulse.

Verification
REQ-030 NUM_PIXELS=4, RAM[0..3]={102030, FFFFFF, 000000, 0000FF}, mode 0, tx_full=0 -> bytes 20, FF, 00, 3F; done is 12 cycles after the FETCH of pixel 0.
REQ-031 Same RAM, mode 2 -> 12 bytes 10,20,30,FF,FF,FF,00,00,00,00,00,FF; mode 1 -> each gray byte emitted three times in a row.
REQ-032 mode 2, tx_full forced to 1 for 5 cycles mid-pixel -> wr_uart=0 throughout the stall, then the byte stream resumes with no loss and no duplicate.
REQ-033 start pulsed again while busy, with a different mode -> ignored; the frame completes in the original mode with exactly one done pulse.
REQ-034 reset asserted during SEND of pixel 2 -> all outputs at their REQ-028 values; a new start sends the frame from address 0.
REQ-035 ADDR_BITS=2 with NUM_PIXELS=4 (the full address space) -> ram_addr sequence 0,1,2,3 with no wrap and done after the last pixel.

Source files
------------

// File: rtl/pixel_stream_tx_if.sv
// pixel_stream_tx_if: control, pixel RAM and UART signals of the frame sender
interface pixel_stream_tx_if #(parameter int ADDR_BITS = 13);
  logic                 start;
  logic [1:0]           mode;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [23:0]          ram_rd_data;
  logic                 tx_full;
  logic                 wr_uart;
  logic [7:0]           w_data;
  logic                 busy;
  logic                 done;
  modport master(input start, mode, ram_rd_data, tx_full, output ram_addr, wr_uart, w_data, busy, done);
  modport slave(output start, mode, ram_rd_data, tx_full, input ram_addr, wr_uart, w_data, busy, done);
endinterface

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: reads a frame from pixel RAM and streams it to a UART as gray or RGB bytes
module pixel_stream_tx #(
  parameter int ADDR_BITS  = 13,
  parameter int NUM_PIXELS = 2 ** ADDR_BITS
) (
  input logic clk,
  input logic reset,
  pixel_stream_tx_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, DONE} state_t;
  localparam logic [ADDR_BITS-1:0] last_idx = ADDR_BITS'(NUM_PIXELS - 1);
  state_t               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [23:0]          pix_q;
  logic [1:0]           byte_q;
  logic [1:0]           mode_q;
  logic [9:0]           gray_sum;
  logic [7:0]           gray;
  logic [7:0]           byte_sel;
  logic                 last_byte;
  logic                 wr;
  // R + 2G + B never exceeds 1020, so the quarter always fits a byte
  assign gray_sum  = {2'b00, pix_q[23:16]} + {1'b0, pix_q[15:8], 1'b0} + {2'b00, pix_q[7:0]};
  assign gray      = 8'(gray_sum >> 2);
  assign byte_sel  = mode_q == 2'd2 ? (byte_q == 2'd0 ? pix_q[23:16] : byte_q == 2'd1 ? pix_q[15:8] : pix_q[7:0]) : gray;
  assign last_byte = mode_q == 2'd0 || byte_q == 2'd2;
  // a byte leaves only in SEND and only when the UART FIFO has room this very cycle
  assign wr           = state_q == SEND && !bus.tx_full;
  assign bus.wr_uart  = wr;
  assign bus.w_data   = wr ? byte_sel : 8'd0;
  assign bus.ram_addr = addr_q;
  assign bus.busy     = state_q == FETCH || state_q == LATCH || state_q == SEND;
  assign bus.done     = state_q == DONE;
  // frame sequencer: fetch, latch and serialise one pixel at a time; addr_q doubles as the pixel index
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
      byte_q  <= '0;
      mode_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mode_q  <= bus.mode == 2'd3 ? 2'd0 : bus.mode;
          addr_q  <= '0;
          state_q <= FETCH;
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          pix_q   <= bus.ram_rd_data;
          byte_q  <= '0;
          state_q <= SEND;
        end
        SEND: if (!bus.tx_full) begin
          byte_q <= byte_q + 2'd1;
          if (last_byte) begin
            if (addr_q == last_idx) state_q <= DONE;
            else begin
              addr_q  <= addr_q + ADDR_BITS'(1);
              state_q <= FETCH;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: random frames against a byte-list model of the pixel stream
module tb_pixel_stream_tx;
  logic clk = 0;
  logic reset;
  int n_cmp = 0, n_err = 0, stall_pct = 0, force_cnt = 0;
  logic [23:0] ram [4];
  logic [7:0] got_q[$];
  int addr_seq[$];
  pixel_stream_tx_if #(.ADDR_BITS(2)) bus();
  pixel_stream_tx #(.ADDR_BITS(2), .NUM_PIXELS(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_rd_data <= ram[bus.ram_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // output rules that hold on every cycle, plus byte and address capture
  always @(negedge clk) begin
    check("wr_while_full", 32'(bus.wr_uart & bus.tx_full), 0);
    check("w_data_idle", bus.wr_uart ? 32'd0 : 32'(bus.w_data), 0);
    check("wr_outside_busy", 32'(bus.wr_uart & ~bus.busy), 0);
    if (bus.wr_uart) got_q.push_back(bus.w_data);
    if (bus.busy && (addr_seq.size() == 0 || addr_seq[$] != int'(bus.ram_addr))) addr_seq.push_back(int'(bus.ram_addr));
  end
  initial begin
    bus.tx_full = 0;
    forever begin
      @(posedge clk); #1;
      if (force_cnt > 0) begin
        bus.tx_full = 1;
        force_cnt--;
      end else bus.tx_full = stall_pct > 0 && int'($urandom_range(99)) < stall_pct;
    end
  end
  task automatic run_frame(input logic [1:0] m, input int stall, input bit hold, input bit restart);
    logic [7:0] exp_q[$];
    int n, bpp, r, g, b, gray;
    bit seen;
    for (int p = 0; p < 4; p++) begin
      r = int'(ram[p][23:16]);
      g = int'(ram[p][15:8]);
      b = int'(ram[p][7:0]);
      gray = (r + 2 * g + b) / 4;
      if (m == 2) begin
        exp_q.push_back(8'(r));
        exp_q.push_back(8'(g));
        exp_q.push_back(8'(b));
      end else if (m == 1) repeat (3) exp_q.push_back(8'(gray));
      else exp_q.push_back(8'(gray));
    end
    bpp = (m == 1 || m == 2) ? 3 : 1;
    got_q.delete();
    addr_seq.delete();
    stall_pct = stall;
    @(posedge clk); #1;
    bus.start = 1;
    bus.mode = m;
    @(posedge clk); #1;
    bus.start = 0;
    bus.mode = 2'($urandom);
    n = -1;
    seen = 0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (hold && n == 3) force_cnt = 5;
      if (restart && n == 4) begin
        bus.start = 1;
        bus.mode = m ^ 2'b10;
      end
      if (restart && n == 5) bus.start = 0;
      seen = bus.done;
    end
    stall_pct = 0;
    check("done_seen", 32'(seen), 1);
    check("busy_at_done", 32'(bus.busy), 0);
    if (stall == 0) check("frame_cycles", n, 4 * (2 + bpp) + (hold ? 5 : 0));
    check("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    check("addr_count", addr_seq.size(), 4);
    for (int i = 0; i < 4 && i < addr_seq.size(); i++) check($sformatf("addr%0d", i), addr_seq[i], i);
    if (restart) begin
      repeat (4) @(negedge clk);
      check("no_refire", 32'(bus.busy | bus.done), 0);
    end
  endtask
  initial begin
    int n, cnt;
    bit any_done;
    reset = 1;
    bus.start = 0;
    bus.mode = 0;
    ram[0] = 24'h102030;
    ram[1] = 24'hFFFFFF;
    ram[2] = 24'h000000;
    ram[3] = 24'h0000FF;
    @(negedge clk);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_wr", 32'(bus.wr_uart), 0);
    check("rst_wdata", 32'(bus.w_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    reset = 0;
    run_frame(0, 0, 0, 0);
    run_frame(2, 0, 0, 0);
    run_frame(1, 0, 0, 0);
    run_frame(3, 0, 0, 0);
    run_frame(2, 0, 1, 0);
    run_frame(0, 0, 0, 1);
    @(posedge clk); #1;
    bus.start = 1;
    bus.mode = 2;
    @(posedge clk); #1;
    bus.start = 0;
    n = 0;
    while (n < 200 && !(bus.wr_uart && bus.ram_addr == 2)) begin
      @(negedge clk);
      n++;
    end
    check("reached_px2", 32'(bus.wr_uart && bus.ram_addr == 2), 1);
    @(posedge clk); #1;
    reset = 1;
    #1;
    check("abort_addr", 32'(bus.ram_addr), 0);
    check("abort_wr", 32'(bus.wr_uart), 0);
    check("abort_wdata", 32'(bus.w_data), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    cnt = got_q.size();
    any_done = 0;
    repeat (3) begin
      @(negedge clk);
      any_done |= bus.done;
    end
    @(posedge clk); #1;
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      any_done |= bus.done;
    end
    check("abort_no_writes", got_q.size(), cnt);
    check("abort_no_done", 32'(any_done), 0);
    run_frame(2, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      for (int p = 0; p < 4; p++) ram[p] = 24'($urandom);
      run_frame(2'($urandom), $urandom_range(1) ? 0 : 35, 0, $urandom_range(3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
